// File: rtl/obi_integrity_responder.sv
// OBI bus responder: grants requests, serves them from a local word memory with in-order
// responses, and checks/generates OBI integrity bits. Define OBI_RESP_JITTER_EN for LFSR response jitter.
module obi_integrity_responder #(
    parameter int         MEM_WORDS  = 1024,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        reqpar_i,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic [12:0] achk_i,
    input  logic        stall_i,
    output logic        gnt_o,
    output logic        gntpar_o,
    output logic        rvalid_o,
    output logic        rvalidpar_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [4:0]  rchk_o,
    output logic        alert_o,
    output logic [15:0] viol_cnt_o
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   fifo_rdata [FIFO_DEPTH];
    logic          fifo_err [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic          full;
    logic          head_valid;
    logic          wait_zero;
    logic          pop;
    logic          accept;
    logic          achk_bad;
    logic          oob;
    logic          reqpar_bad;
    logic          viol;
    logic [12:0]   achk_exp;
    logic [AW-1:0] word_idx;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          alert_q;
    logic [15:0]   viol_cnt_q;
    logic          unused_achk_hi;

    // Address-phase check bits the core should have sent for this request
    always_comb begin
        achk_exp = '0;
        for (int n = 0; n < 4; n++) begin
            achk_exp[n]     = ~^addr_i[8*n +: 8];
            achk_exp[5 + n] = ^wdata_i[8*n +: 8];
        end
        achk_exp[4] = ^{we_i, be_i};
    end

    assign unused_achk_hi = ^{achk_i[12:9], achk_exp[12:9]};

    assign achk_bad   = (achk_i[4:0] != achk_exp[4:0]) |
                        (we_i & (achk_i[8:5] != achk_exp[8:5]));
    assign reqpar_bad = (reqpar_i == req_i);
    assign oob        = |addr_i[31:AW+2];
    assign word_idx   = addr_i[AW+1:2];

    assign full       = (count_q == CW'(FIFO_DEPTH));
    assign head_valid = (count_q != '0);
    assign pop        = head_valid & wait_zero & ~rst_i;
    assign gnt_o      = req_i & ~stall_i & ~rst_i & (~full | pop);
    assign accept     = req_i & gnt_o;
    assign viol       = reqpar_bad | (accept & achk_bad);

    assign rsp_err    = oob | achk_bad;
    assign rsp_rdata  = (we_i | rsp_err) ? 32'h0 : mem[word_idx];

    always_ff @(posedge clk_i) begin
        if (accept && we_i && !rsp_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            fifo_rdata[wr_ptr_q] <= rsp_rdata;
            fifo_err[wr_ptr_q]   <= rsp_err;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef OBI_RESP_JITTER_EN
    logic [7:0] lfsr_q;
    logic [1:0] wait_q;
    logic       new_head;

    // A new entry reaches the head either by landing in an empty FIFO or by the old head leaving
    assign new_head = (accept & (count_q == '0)) |
                      (pop & ((count_q > CW'(1)) | accept));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
            wait_q <= 2'd0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
            if (new_head) begin
                wait_q <= lfsr_q[1:0];
            end else if (wait_q != 2'd0) begin
                wait_q <= wait_q - 2'd1;
            end
        end
    end

    assign wait_zero = (wait_q == 2'd0);
`else
    logic [7:0] unused_seed;
    assign unused_seed = LFSR_SEED;
    assign wait_zero   = 1'b1;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alert_q    <= 1'b0;
            viol_cnt_q <= 16'h0;
        end else begin
            alert_q <= viol;
            if (viol && (viol_cnt_q != 16'hFFFF)) begin
                viol_cnt_q <= viol_cnt_q + 16'h1;
            end
        end
    end

    assign rvalid_o    = pop;
    assign rvalidpar_o = ~pop;
    assign gntpar_o    = ~gnt_o;
    assign rdata_o     = pop ? fifo_rdata[rd_ptr_q] : 32'h0;
    assign err_o       = pop & fifo_err[rd_ptr_q];
    assign alert_o     = alert_q;
    assign viol_cnt_o  = viol_cnt_q;

    always_comb begin
        rchk_o = '0;
        for (int n = 0; n < 4; n++) begin
            rchk_o[n] = ^rdata_o[8*n +: 8];
        end
        rchk_o[4] = err_o;
    end

endmodule

// File: tb/tb_obi_integrity_responder.sv
// Self-checking bench for obi_integrity_responder: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_obi_integrity_responder;
    localparam int MEM_WORDS = 1024;
    localparam int DEPTH     = 4;
    localparam int AW        = $clog2(MEM_WORDS);

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        reqpar_i;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic [12:0] achk_i;
    logic        stall_i;
    logic        gnt_o;
    logic        gntpar_o;
    logic        rvalid_o;
    logic        rvalidpar_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [4:0]  rchk_o;
    logic        alert_o;
    logic [15:0] viol_cnt_o;

    always #5 clk_i = ~clk_i;

    obi_integrity_responder #(
        .MEM_WORDS (MEM_WORDS),
        .FIFO_DEPTH(DEPTH),
        .LFSR_SEED (8'hA5)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .reqpar_i   (reqpar_i),
        .addr_i     (addr_i),
        .we_i       (we_i),
        .be_i       (be_i),
        .wdata_i    (wdata_i),
        .achk_i     (achk_i),
        .stall_i    (stall_i),
        .gnt_o      (gnt_o),
        .gntpar_o   (gntpar_o),
        .rvalid_o   (rvalid_o),
        .rvalidpar_o(rvalidpar_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .rchk_o     (rchk_o),
        .alert_o    (alert_o),
        .viol_cnt_o (viol_cnt_o)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t       q[$];
    logic [31:0] mem_m [MEM_WORDS];
    logic        m_alert = 1'b0;
    logic [15:0] m_cnt   = 16'h0;
    int          checks  = 0;
    int          errors  = 0;
    int          cyc     = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic par1(input logic [31:0] v);
        return ($countones(v) % 2) == 1;
    endfunction

    // Check bits a well-behaved core sends; bits that are not checked are randomized
    function automatic logic [12:0] good_achk(input logic [31:0] a, input logic w,
                                              input logic [3:0] b, input logic [31:0] d);
        logic [12:0] r;
        r = 13'($urandom);
        for (int n = 0; n < 4; n++) begin
            r[n] = !par1({24'h0, a[8*n +: 8]});
            if (w) r[5+n] = par1({24'h0, d[8*n +: 8]});
        end
        r[4] = par1({27'h0, w, b});
        return r;
    endfunction

    function automatic logic achk_ok(input logic [12:0] c, input logic [31:0] a, input logic w,
                                     input logic [3:0] b, input logic [31:0] d);
        logic ok;
        ok = (c[4] == par1({27'h0, w, b}));
        for (int n = 0; n < 4; n++) begin
            if (c[n] != !par1({24'h0, a[8*n +: 8]})) ok = 1'b0;
            if (w && (c[5+n] != par1({24'h0, d[8*n +: 8]}))) ok = 1'b0;
        end
        return ok;
    endfunction

    function automatic logic [4:0] rchk_of(input logic [31:0] d, input logic e);
        logic [4:0] r;
        for (int n = 0; n < 4; n++) r[n] = par1({24'h0, d[8*n +: 8]});
        r[4] = e;
        return r;
    endfunction

    // Model: responses queue in order; without jitter each one is due the cycle after its accept
    always @(negedge clk_i) begin : cmp
        logic        exp_gnt;
        logic        exp_rv;
        logic        acc;
        logic        viol;
        logic [31:0] exp_rd;
        logic        exp_err;
        resp_t       head;
        resp_t       r;
        cyc++;
        head = (q.size() > 0) ? q[0] : '0;
`ifdef OBI_RESP_JITTER_EN
        exp_rv = rvalid_o && !rst_i && (q.size() > 0);
`else
        exp_rv = !rst_i && (q.size() > 0);
`endif
        exp_gnt = req_i && !stall_i && !rst_i && ((q.size() < DEPTH) || exp_rv);
        exp_rd  = exp_rv ? head.rdata : 32'h0;
        exp_err = exp_rv ? head.err : 1'b0;
        chk("gnt", {31'h0, gnt_o}, {31'h0, exp_gnt});
        chk("gntpar", {31'h0, gntpar_o}, {31'h0, !exp_gnt});
        chk("rvalid", {31'h0, rvalid_o}, {31'h0, exp_rv});
        chk("rvalidpar", {31'h0, rvalidpar_o}, {31'h0, !exp_rv});
        chk("rdata", rdata_o, exp_rd);
        chk("err", {31'h0, err_o}, {31'h0, exp_err});
        chk("rchk", {27'h0, rchk_o}, {27'h0, rchk_of(exp_rd, exp_err)});
        chk("alert", {31'h0, alert_o}, {31'h0, m_alert});
        chk("viol_cnt", {16'h0, viol_cnt_o}, {16'h0, m_cnt});
        acc = req_i && exp_gnt;
        if (rst_i) begin
            q.delete();
            m_alert = 1'b0;
            m_cnt   = 16'h0;
        end else begin
            viol = (reqpar_i == req_i) || (acc && !achk_ok(achk_i, addr_i, we_i, be_i, wdata_i));
            if (exp_rv) head = q.pop_front();
            if (acc) begin
                r.err   = (addr_i[31:AW+2] != '0) || !achk_ok(achk_i, addr_i, we_i, be_i, wdata_i);
                r.rdata = (we_i || r.err) ? 32'h0 : mem_m[addr_i[AW+1:2]];
                if (we_i && !r.err) begin
                    for (int b = 0; b < 4; b++)
                        if (be_i[b]) mem_m[addr_i[AW+1:2]][8*b +: 8] = wdata_i[8*b +: 8];
                end
                q.push_back(r);
            end
            m_alert = viol;
            if (viol && (m_cnt != 16'hFFFF)) m_cnt = m_cnt + 16'h1;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        req_i    = 1'b0;
        reqpar_i = 1'b1;
        we_i     = 1'b0;
        be_i     = 4'h0;
        addr_i   = 32'h0;
        wdata_i  = 32'h0;
        achk_i   = good_achk(32'h0, 1'b0, 4'h0, 32'h0);
        stall_i  = 1'b0;
    endtask

    task automatic xfer(input logic w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [12:0] flip);
        bit done;
        done     = 1'b0;
        req_i    = 1'b1;
        reqpar_i = 1'b0;
        we_i     = w;
        addr_i   = a;
        be_i     = b;
        wdata_i  = d;
        achk_i   = good_achk(a, w, b, d) ^ flip;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            done = gnt_o;
            step();
        end
        chk("xfer_granted", {31'h0, done}, 32'h1);
        idle_inputs();
    endtask

    task automatic get_resp(output logic [31:0] rd, output logic er, output logic [4:0] rc,
                            output bit got);
        got = 1'b0;
        rd  = 32'h0;
        er  = 1'b0;
        rc  = 5'h0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk_i);
            if (rvalid_o) begin
                got = 1'b1;
                rd  = rdata_o;
                er  = err_o;
                rc  = rchk_o;
            end
            step();
        end
    endtask

    logic [31:0] rd;
    logic        er;
    logic [4:0]  rc;
    bit          got;
    int          n_gnt;
    int          n_rv;
    logic [31:0] rd5;
    logic [3:0]  al;
    logic [31:0] a;
    logic [12:0] c;

    initial begin
        idle_inputs();
        rst_i    = 1'b1;
        req_i    = 1'b1;
        reqpar_i = 1'b0;
        repeat (3) step();
        @(negedge clk_i);
        chk("rst_gnt", {31'h0, gnt_o}, 32'h0);
        chk("rst_gntpar", {31'h0, gntpar_o}, 32'h1);
        chk("rst_rvalid", {31'h0, rvalid_o}, 32'h0);
        chk("rst_rvalidpar", {31'h0, rvalidpar_o}, 32'h1);
        chk("rst_rdata", rdata_o, 32'h0);
        chk("rst_rchk", {27'h0, rchk_o}, 32'h0);
        chk("rst_alert", {31'h0, alert_o}, 32'h0);
        chk("rst_viol_cnt", {16'h0, viol_cnt_o}, 32'h0);
        step();
        rst_i = 1'b0;
        idle_inputs();
        step();

        for (int w = 0; w < 16; w++) xfer(1'b1, 32'(w * 4), 4'hF, 32'hFFFF_FFFF, 13'h0);
        repeat (6) step();

        // Partial write then read back
        xfer(1'b1, 32'h10, 4'b0011, 32'hDEAD_BEEF, 13'h0);
        get_resp(rd, er, rc, got);
        chk("wr_resp_got", {31'h0, got}, 32'h1);
        chk("wr_resp_rdata", rd, 32'h0);
        xfer(1'b0, 32'h10, 4'hF, 32'h0, 13'h0);
        get_resp(rd, er, rc, got);
        chk("rd10_got", {31'h0, got}, 32'h1);
        chk("rd10_rdata", rd, 32'hFFFF_BEEF);
        chk("rd10_err", {31'h0, er}, 32'h0);
        chk("rd10_rchk", {27'h0, rc}, 32'h01);
        chk("rd10_alert", {31'h0, alert_o}, 32'h0);

        // Out-of-range read
        xfer(1'b0, 32'h0001_0000, 4'hF, 32'h0, 13'h0);
        get_resp(rd, er, rc, got);
        chk("oob_got", {31'h0, got}, 32'h1);
        chk("oob_err", {31'h0, er}, 32'h1);
        chk("oob_rdata", rd, 32'h0);
        chk("oob_rchk", {27'h0, rc}, 32'h10);
        repeat (4) step();

        // reqpar equal to req for three cycles
        chk("pre_reqpar_cnt", {16'h0, viol_cnt_o}, 32'h0);
        req_i    = 1'b1;
        reqpar_i = 1'b1;
        addr_i   = 32'h0;
        be_i     = 4'hF;
        achk_i   = good_achk(32'h0, 1'b0, 4'hF, wdata_i);
        for (int k = 0; k < 4; k++) begin
            step();
            if (k == 2) idle_inputs();
            @(negedge clk_i);
            al[k] = alert_o;
        end
        chk("reqpar_alert", {28'h0, al}, 32'h7);
        chk("reqpar_cnt", {16'h0, viol_cnt_o}, 32'h3);
        step();
        repeat (6) step();

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();

        // Corrupted achk on a write: suppressed and flagged
        xfer(1'b1, 32'h20, 4'hF, 32'h1234_5678, 13'h004);
        get_resp(rd, er, rc, got);
        chk("badachk_got", {31'h0, got}, 32'h1);
        chk("badachk_err", {31'h0, er}, 32'h1);
        chk("badachk_rdata", rd, 32'h0);
        chk("badachk_cnt", {16'h0, viol_cnt_o}, 32'h1);
        xfer(1'b0, 32'h20, 4'hF, 32'h0, 13'h0);
        get_resp(rd, er, rc, got);
        chk("badachk_mem", rd, 32'hFFFF_FFFF);
        chk("badachk_mem_err", {31'h0, er}, 32'h0);
        repeat (6) step();

        // Six back-to-back reads
        n_gnt = 0;
        n_rv  = 0;
        rd5   = 32'h0;
        for (int k = 0; k < 8; k++) begin
            if (k < 6) begin
                req_i    = 1'b1;
                reqpar_i = 1'b0;
                we_i     = 1'b0;
                addr_i   = 32'(k * 4);
                be_i     = 4'hF;
                achk_i   = good_achk(addr_i, 1'b0, 4'hF, wdata_i);
            end else begin
                idle_inputs();
            end
            @(negedge clk_i);
            if (k < 6 && gnt_o) n_gnt++;
            if (rvalid_o) n_rv++;
            if (k == 5) rd5 = rdata_o;
            step();
        end
`ifndef OBI_RESP_JITTER_EN
        chk("b2b_gnt", n_gnt, 6);
        chk("b2b_rvalid", n_rv, 6);
        chk("b2b_word4", rd5, 32'hFFFF_BEEF);
`endif
        repeat (8) step();

        // Reset one cycle after two accepts
        n_rv = 0;
        req_i    = 1'b1;
        reqpar_i = 1'b0;
        addr_i   = 32'h0;
        be_i     = 4'hF;
        achk_i   = good_achk(32'h0, 1'b0, 4'hF, wdata_i);
        step();
        addr_i   = 32'h4;
        achk_i   = good_achk(32'h4, 1'b0, 4'hF, wdata_i);
        step();
        idle_inputs();
        rst_i = 1'b1;
        @(negedge clk_i);
        if (rvalid_o) n_rv++;
        step();
        rst_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (rvalid_o) n_rv++;
            step();
        end
        chk("rst_mid_rvalid", n_rv, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            rst_i   = ($urandom_range(0, 299) == 0);
            req_i   = ($urandom_range(0, 9) < 7);
            stall_i = ($urandom_range(0, 4) == 0);
            we_i    = 1'($urandom_range(0, 1));
            be_i    = 4'($urandom);
            wdata_i = $urandom;
            a = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            addr_i = a;
            c = good_achk(a, we_i, be_i, wdata_i);
            if ($urandom_range(0, 15) == 0) c = c ^ 13'(1 << $urandom_range(0, 12));
            achk_i   = c;
            reqpar_i = !req_i;
            if ($urandom_range(0, 39) == 0) reqpar_i = req_i;
            step();
        end
        rst_i = 1'b0;
        idle_inputs();
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
